// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the register file arbiter and its requesters.
// The master side issues requests; the slave side grants them and drives the register file.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 8
);
  logic              clear_start;
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              gnt0;
  logic              gnt1;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic              busy;

  modport master (
    output clear_start, req0, addr0, data0, req1, addr1, data1,
    input  gnt0, gnt1, reg_we, reg_waddr, reg_wdata, busy
  );

  modport slave (
    input  clear_start, req0, addr0, data0, req1, addr1, data1,
    output gnt0, gnt1, reg_we, reg_waddr, reg_wdata, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between core writeback (port 0) and debug/loader (port 1),
// zeroing every register after reset or on clear_start.
module regfile_write_arbiter #(
  parameter int ADDR_W   = 1,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] index_reg, index_next;
  logic              ptr_reg, ptr_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic              busy_reg, busy_next;

  logic [1:0]        req_vec;
  logic [1:0]        elig;
  logic [ADDR_W-1:0] addr_arr [2];
  logic [DATA_W-1:0] data_arr [2];

  assign req_vec     = {bus.req1, bus.req0};
  assign addr_arr[0] = bus.addr0;
  assign addr_arr[1] = bus.addr1;
  assign data_arr[0] = bus.data0;
  assign data_arr[1] = bus.data1;

  // A port that was granted last cycle may still be dropping req; skip it once.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req_vec[gi] & ~gnt_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    ptr_next   = ptr_reg;
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    gnt_next   = 2'b00;
    busy_next  = busy_reg;

    case (state_reg)
      ST_CLEAR: begin
        we_next    = 1'b1;
        waddr_next = index_reg;
        wdata_next = '0;
        if (index_reg == LAST_IDX) begin
          busy_next  = 1'b0;
          state_next = ST_RUN;
          index_next = '0;
        end else begin
          index_next = index_reg + ADDR_W'(1);
        end
      end

      ST_RUN: begin
        if (bus.clear_start) begin
          state_next = ST_CLEAR;
          busy_next  = 1'b1;
          index_next = '0;
        end else if (elig != 2'b00) begin
          // ptr_reg names the last winner; on a tie the other port goes.
          if (elig[1] && (!elig[0] || !ptr_reg)) begin
            gnt_next   = 2'b10;
            ptr_next   = 1'b1;
            waddr_next = addr_arr[1];
            wdata_next = data_arr[1];
          end else begin
            gnt_next   = 2'b01;
            ptr_next   = 1'b0;
            waddr_next = addr_arr[0];
            wdata_next = data_arr[0];
          end
          we_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_CLEAR;
        busy_next  = 1'b1;
        index_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_CLEAR;
      index_reg <= '0;
      ptr_reg   <= 1'b1;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      gnt_reg   <= 2'b00;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      ptr_reg   <= ptr_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      gnt_reg   <= gnt_next;
      busy_reg  <= busy_next;
    end
  end

  assign bus.reg_we    = we_reg;
  assign bus.reg_waddr = waddr_reg;
  assign bus.reg_wdata = wdata_reg;
  assign bus.gnt0      = gnt_reg[0];
  assign bus.gnt1      = gnt_reg[1];
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus queues expected writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_regfile_write_arbiter;

  localparam int ADDR_W   = 1;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 2;

  typedef struct packed {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              g0;
    logic              g1;
    logic              busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q [$];

  regfile_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_write_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input int c, input int a, input int d, input logic g0, input logic g1,
                      input logic b);
    exp_t e;
    e.cyc  = c;
    e.addr = ADDR_W'(a);
    e.data = DATA_W'(d);
    e.g0   = g0;
    e.g1   = g1;
    e.busy = b;
    sb_q.push_back(e);
  endtask

  // Expected zero writes of a clear sequence whose first write lands at cycle c.
  task automatic push_clear(input int c);
    for (int i = 0; i < NUM_REGS; i++)
      push(c + i, i, 0, 1'b0, 1'b0, (i == NUM_REGS - 1) ? 1'b0 : 1'b1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},    32'(bus.reg_we),    32'h0);
    check({tag, "_waddr"}, 32'(bus.reg_waddr), 32'h0);
    check({tag, "_wdata"}, 32'(bus.reg_wdata), 32'h0);
    check({tag, "_gnt"},   32'({bus.gnt1, bus.gnt0}), 32'h0);
    check({tag, "_busy"},  32'(bus.busy),      32'h1);
  endtask

  // Monitor: every write must match the next queued expectation, including its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.reg_we === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: write addr=%0h data=%0h gnt=%b%b at cycle %0d, expected none",
                   bus.reg_waddr, bus.reg_wdata, bus.gnt1, bus.gnt0, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.cyc != cyc || e.addr !== bus.reg_waddr || e.data !== bus.reg_wdata ||
              e.g0 !== bus.gnt0 || e.g1 !== bus.gnt1 || e.busy !== bus.busy) begin
            errors++;
            $display("FAIL sb_write: got cyc=%0d addr=%0h data=%0h g0=%b g1=%b busy=%b, expected cyc=%0d addr=%0h data=%0h g0=%b g1=%b busy=%b",
                     cyc, bus.reg_waddr, bus.reg_wdata, bus.gnt0, bus.gnt1, bus.busy,
                     e.cyc, e.addr, e.data, e.g0, e.g1, e.busy);
          end else begin
            $display("ok   write cyc=%0d addr=%0h data=%0h g0=%b g1=%b busy=%b",
                     cyc, bus.reg_waddr, bus.reg_wdata, bus.gnt0, bus.gnt1, bus.busy);
          end
        end
      end else begin
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
          errors++;
          $display("FAIL idle_gnt: gnt=%b%b without write at cycle %0d, expected 00",
                   bus.gnt1, bus.gnt0, cyc);
        end
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.clear_start = 1'b0;
    bus.req0        = 1'b0;
    bus.addr0       = '0;
    bus.data0       = '0;
    bus.req1        = 1'b0;
    bus.addr1       = '0;
    bus.data1       = '0;

    step(3);
    check_reset_values("reset");

    // Reset release: two zero writes, then idle.
    rst_n = 1'b1;
    push_clear(cyc + 1);
    step(3);
    check("post_clear_we", 32'(bus.reg_we), 32'h0);
    check("post_clear_busy", 32'(bus.busy), 32'h0);

    // Both ports held: grants alternate starting with port 0.
    bus.req0 = 1'b1; bus.addr0 = 1'b0; bus.data0 = 8'h11;
    bus.req1 = 1'b1; bus.addr1 = 1'b1; bus.data1 = 8'h22;
    push(cyc + 1, 0, 8'h11, 1'b1, 1'b0, 1'b0);
    push(cyc + 2, 1, 8'h22, 1'b0, 1'b1, 1'b0);
    push(cyc + 3, 0, 8'h11, 1'b1, 1'b0, 1'b0);
    push(cyc + 4, 1, 8'h22, 1'b0, 1'b1, 1'b0);
    step(4);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step(1);

    // Single port-0 write, dropped on grant.
    bus.req0 = 1'b1; bus.addr0 = 1'b1; bus.data0 = 8'hA5;
    push(cyc + 1, 1, 8'hA5, 1'b1, 1'b0, 1'b0);
    step(1);
    bus.req0 = 1'b0;
    step(1);
    check("single_after_we", 32'(bus.reg_we), 32'h0);
    check("single_after_gnt0", 32'(bus.gnt0), 32'h0);

    // clear_start beats a pending req0; held one extra cycle to confirm it is ignored in CLEAR.
    bus.clear_start = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 1'b0; bus.data0 = 8'h5A;
    push_clear(cyc + 2);
    push(cyc + 4, 0, 8'h5A, 1'b1, 1'b0, 1'b0);
    step(1);
    check("clrstart_we", 32'(bus.reg_we), 32'h0);
    check("clrstart_busy", 32'(bus.busy), 32'h1);
    check("clrstart_gnt0", 32'(bus.gnt0), 32'h0);
    step(1);
    bus.clear_start = 1'b0;
    step(2);
    bus.req0 = 1'b0;
    step(1);

    // req1 raised during CLEAR: granted on the first edge after busy falls.
    bus.clear_start = 1'b1;
    push_clear(cyc + 2);
    step(1);
    bus.clear_start = 1'b0;
    bus.req1 = 1'b1; bus.addr1 = 1'b0; bus.data1 = 8'h3C;
    push(cyc + 3, 0, 8'h3C, 1'b0, 1'b1, 1'b0);
    step(3);
    bus.req1 = 1'b0;
    step(1);

    // Reset mid-clear after the address 0 write; clear restarts from 0.
    bus.clear_start = 1'b1;
    push(cyc + 2, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1);
    bus.clear_start = 1'b0;
    step(1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("midclear_rst");
    step(1);
    rst_n = 1'b1;
    push_clear(cyc + 1);
    step(4);

    check("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
